// File: rtl/scan_access_controller.sv
// scan_access_controller: streams 16-bit host words serially into the datapath
// scan chain (LSB first) while capturing the bits leaving on sdo and returning
// them as 16-bit words. Holds the core frozen for the duration of a pass.
module scan_access_controller #(
  parameter int unsigned CHAIN_LEN = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        core_hold,
  input  logic [15:0] in_word,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        test,
  output logic        sdi,
  input  logic        sdo
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned BIT_W  = $clog2(WORD_W);
  localparam int unsigned WORDS  = CHAIN_LEN / WORD_W;
  localparam int unsigned CNT_W  = $clog2(WORDS) + 1;

  // Chain length must be a whole, non-zero number of words.
  generate
    if (CHAIN_LEN == 0 || (CHAIN_LEN % WORD_W) != 0) begin : g_bad_len
      $error("scan_access_controller: CHAIN_LEN must be a non-zero multiple of 16");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    EMIT  = 2'd3
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    word_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [WORD_W-1:0]   in_sr;
  logic [WORD_W-1:0]   out_sr;
  logic                abort_act;
  logic                last_bit;
  logic                last_word;

  assign abort_act = abort && (state != IDLE);
  assign last_bit  = (bit_cnt == BIT_W'(WORD_W - 1));
  assign last_word = (word_cnt == CNT_W'(WORDS - 1));

  // Pass sequencing and all handshake/scan control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      word_cnt  <= '0;
      busy      <= 1'b0;
      core_hold <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      test      <= 1'b0;
      sdi       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort_act) begin
        // Cancel wins over any handshake this cycle; chain is left mid-shift.
        state     <= IDLE;
        busy      <= 1'b0;
        core_hold <= 1'b0;
        in_ready  <= 1'b0;
        out_valid <= 1'b0;
        test      <= 1'b0;
        sdi       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= LOAD;
              word_cnt  <= '0;
              busy      <= 1'b1;
              core_hold <= 1'b1;
              in_ready  <= 1'b1;
            end
          end
          LOAD: begin
            if (in_valid && in_ready) begin
              state    <= SHIFT;
              in_ready <= 1'b0;
              test     <= 1'b1;
              sdi      <= in_word[0];
            end
          end
          SHIFT: begin
            // sdi presents the bit that in_sr[0] will hold after this edge.
            sdi <= in_sr[1];
            if (last_bit) begin
              state     <= EMIT;
              test      <= 1'b0;
              sdi       <= 1'b0;
              out_valid <= 1'b1;
            end
          end
          EMIT: begin
            if (out_valid && out_ready) begin
              out_valid <= 1'b0;
              word_cnt  <= word_cnt + CNT_W'(1);
              if (last_word) begin
                state     <= IDLE;
                done      <= 1'b1;
                busy      <= 1'b0;
                core_hold <= 1'b0;
              end else begin
                state    <= LOAD;
                in_ready <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Serial datapath: input/capture shift registers, bit counter, output word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_sr    <= '0;
      out_sr   <= '0;
      bit_cnt  <= '0;
      out_word <= '0;
    end else begin
      if (state == LOAD && in_valid && in_ready && !abort) begin
        in_sr   <= in_word;
        bit_cnt <= '0;
      end else if (state == SHIFT) begin
        in_sr   <= {1'b0, in_sr[WORD_W-1:1]};
        out_sr  <= {sdo, out_sr[WORD_W-1:1]};
        bit_cnt <= bit_cnt + BIT_W'(1);
        // Capture the completed word so out_word is stable throughout EMIT.
        if (last_bit && !abort) begin
          out_word <= {sdo, out_sr[WORD_W-1:1]};
        end
      end
    end
  end

endmodule

// File: tb/tb_scan_access_controller.sv
// Bench for scan_access_controller with a 32-bit scan chain model.
module tb_scan_access_controller;

  localparam int unsigned CL = 32;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic        core_hold;
  logic [15:0] in_word;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic        test;
  logic        sdi;
  logic        sdo;

  scan_access_controller #(.CHAIN_LEN(CL)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .core_hold (core_hold),
    .in_word   (in_word),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .test      (test),
    .sdi       (sdi),
    .sdo       (sdo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scan chain model: bit 0 is the tail feeding sdo, sdi enters at bit 31.
  logic [CL-1:0] chain;
  logic [CL-1:0] preload_val;
  logic          preload_req;
  assign sdo = chain[0];
  always @(posedge clk) begin
    if (preload_req) chain <= preload_val;
    else if (test)   chain <= {sdi, chain[CL-1:1]};
  end

  int          checks;
  int          errors;
  int          done_cnt;
  int          test_cnt;
  int          out_cnt;
  logic [15:0] exp_q[$];
  logic [15:0] prev_word;
  logic        prev_stall;

  // Monitor: pops the scoreboard on every output handshake, watches stalls.
  initial begin
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (test) test_cnt++;
        checks++;
        if (core_hold !== busy) begin
          errors++;
          $display("FAIL core_hold_eq_busy: core_hold=%b busy=%b", core_hold, busy);
        end
        if (out_valid && out_ready) begin
          logic [15:0] e;
          out_cnt++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_word_unexpected: got %h, none expected", out_word);
          end else begin
            e = exp_q.pop_front();
            if (out_word !== e) begin
              errors++;
              $display("FAIL out_word: got %h expected %h", out_word, e);
            end
          end
        end
        if (prev_stall) begin
          checks++;
          if (out_word !== prev_word || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL emit_stall_hold: word %h valid %b, expected word %h valid 1",
                     out_word, out_valid, prev_word);
          end
        end
        if (in_ready || out_valid) begin
          checks++;
          if (test !== 1'b0) begin
            errors++;
            $display("FAIL test_low_in_handshake: test=%b expected 0", test);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_word  = out_word;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_in_ready();
    int n = 0;
    while (!in_ready && n < 300) begin step(); n++; end
    if (!in_ready) chk("timeout_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!out_valid && n < 300) begin step(); n++; end
    if (!out_valid) chk("timeout_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin step(); n++; end
    if (busy) chk("timeout_idle", 32'(busy), 32'd0);
  endtask

  task automatic preload(input logic [31:0] v);
    preload_val = v;
    preload_req = 1'b1;
    step();
    preload_req = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Present one word in LOAD after in_delay idle cycles; leaves bench in shift cycle 0.
  task automatic feed(input logic [15:0] w, input int in_delay);
    wait_in_ready();
    repeat (in_delay) step();
    in_valid = 1'b1;
    in_word  = w;
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_pass(input logic [15:0] w0, input logic [15:0] w1,
                          input logic [15:0] e0, input logic [15:0] e1,
                          input logic [31:0] exp_chain,
                          input int in_delay, input int out_hold, input bit mid_start);
    int d0, t0, o0;
    logic [15:0] ws[2];
    ws[0] = w0;
    ws[1] = w1;
    d0 = done_cnt;
    t0 = test_cnt;
    o0 = out_cnt;
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      out_ready = (out_hold == 0);
      feed(ws[i], in_delay);
      if (mid_start && i == 0) pulse_start();
      if (out_hold > 0) begin
        wait_out_valid();
        repeat (out_hold - 1) step();
        out_ready = 1'b1;
        step();
      end
    end
    out_ready = 1'b1;
    wait_idle();
    step();
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("test_cycles", 32'(test_cnt - t0), 32'd32);
    chk("out_words", 32'(out_cnt - o0), 32'd2);
    chk("chain_after", chain, exp_chain);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int d0;
    checks      = 0;
    errors      = 0;
    done_cnt    = 0;
    test_cnt    = 0;
    out_cnt     = 0;
    rst         = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    in_word     = '0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    preload_req = 1'b0;
    preload_val = '0;
    #1;
    chk("reset_ctrl", {27'd0, busy, done, core_hold, in_ready, out_valid}, 32'd0);
    chk("reset_scan", {30'd0, test, sdi}, 32'd0);
    chk("reset_out_word", 32'(out_word), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // Basic pass.
    preload(32'hCAFE_1234);
    run_pass(16'hAAAA, 16'h5555, 16'h1234, 16'hCAFE, 32'h5555_AAAA, 0, 0, 1'b0);

    // Back-to-back passes: second returns what the first wrote.
    run_pass(16'h0001, 16'h8000, 16'hAAAA, 16'h5555, 32'h8000_0001, 0, 0, 1'b0);
    run_pass(16'hFFFF, 16'h0000, 16'h0001, 16'h8000, 32'h0000_FFFF, 0, 0, 1'b0);

    // Backpressure in LOAD and EMIT gives the same result as unstalled.
    preload(32'hCAFE_1234);
    run_pass(16'hAAAA, 16'h5555, 16'h1234, 16'hCAFE, 32'h5555_AAAA, 5, 10, 1'b0);

    // Abort in shift cycle 7 of word 1: 24 bits shifted, no Done.
    preload(32'hCAFE_1234);
    d0 = done_cnt;
    exp_q.push_back(16'h1234);
    out_ready = 1'b1;
    pulse_start();
    feed(16'h1111, 0);
    feed(16'h22EE, 0);
    repeat (7) step();
    chk("abort_pre_test", 32'(test), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle", {28'd0, busy, test, in_ready, out_valid}, 32'd0);
    step();
    step();
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_chain", chain, 32'hEE11_11CA);
    chk("abort_scoreboard", 32'(exp_q.size()), 32'd0);
    run_pass(16'h1357, 16'h2468, 16'h11CA, 16'hEE11, 32'h2468_1357, 0, 0, 1'b0);

    // Async reset between edges mid-shift.
    d0 = done_cnt;
    pulse_start();
    feed(16'hFFFF, 0);
    repeat (3) step();
    chk("rst_pre_scan", {30'd0, test, sdi}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", {28'd0, test, sdi, busy, out_valid}, 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
    preload(32'h0F0F_F0F0);
    run_pass(16'hBEEF, 16'hDEAD, 16'hF0F0, 16'h0F0F, 32'hDEAD_BEEF, 0, 0, 1'b0);

    // Start pulsed while busy is ignored.
    run_pass(16'h0000, 16'h0000, 16'hBEEF, 16'hDEAD, 32'h0000_0000, 0, 0, 1'b1);
    repeat (3) step();
    chk("no_restart_after_busy_start", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
